// File: rtl/alu_74382_pkg.sv
// Shared definitions for the 74382 slice and the wide sequencer that drives it:
// function-select codes and the sequencer state encoding.
package alu_74382_pkg;

  localparam logic [2:0] SEL_CLEAR  = 3'b000;
  localparam logic [2:0] SEL_B_MINUS_A = 3'b001;
  localparam logic [2:0] SEL_A_MINUS_B = 3'b010;
  localparam logic [2:0] SEL_ADD    = 3'b011;
  localparam logic [2:0] SEL_XOR    = 3'b100;
  localparam logic [2:0] SEL_OR     = 3'b101;
  localparam logic [2:0] SEL_AND    = 3'b110;
  localparam logic [2:0] SEL_PRESET = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Only the three arithmetic selects produce meaningful carry/overflow.
  function automatic logic is_arith(input logic [2:0] sel);
    return (sel == SEL_B_MINUS_A) || (sel == SEL_A_MINUS_B) || (sel == SEL_ADD);
  endfunction

endpackage

// File: rtl/alu_74382.sv
// Combinational 74382-style ALU slice: add, two subtract directions, logic ops and
// constants, with carry out and signed overflow for the arithmetic functions.
module alu_74382
  import alu_74382_pkg::*;
#(
  parameter int OPERAND_W = 4,
  parameter int RESULT_W  = OPERAND_W
) (
  input  logic [2:0]           sel,
  input  logic                 carry_in,
  input  logic [OPERAND_W-1:0] port_a,
  input  logic [OPERAND_W-1:0] port_b,
  output logic [RESULT_W-1:0]  result,
  output logic                 carry_out,
  output logic                 overflow
);

  logic [OPERAND_W-1:0] op_x;
  logic [OPERAND_W-1:0] op_y;
  logic [OPERAND_W:0]   sum;
  logic [OPERAND_W-1:0] f;

  // Subtraction is x + ~y + carry_in, so carry_in=1 means "no borrow".
  always_comb begin
    op_x = port_a;
    op_y = port_b;
    case (sel)
      SEL_B_MINUS_A: begin
        op_x = port_b;
        op_y = ~port_a;
      end
      SEL_A_MINUS_B: begin
        op_x = port_a;
        op_y = ~port_b;
      end
      default: begin
        op_x = port_a;
        op_y = port_b;
      end
    endcase
  end

  assign sum = {1'b0, op_x} + {1'b0, op_y} + (OPERAND_W+1)'(carry_in);

  always_comb begin
    f = '0;
    case (sel)
      SEL_CLEAR:     f = '0;
      SEL_B_MINUS_A: f = sum[OPERAND_W-1:0];
      SEL_A_MINUS_B: f = sum[OPERAND_W-1:0];
      SEL_ADD:       f = sum[OPERAND_W-1:0];
      SEL_XOR:       f = port_a ^ port_b;
      SEL_OR:        f = port_a | port_b;
      SEL_AND:       f = port_a & port_b;
      SEL_PRESET:    f = '1;
      default:       f = '0;
    endcase
  end

  assign result    = RESULT_W'(f);
  assign carry_out = is_arith(sel) & sum[OPERAND_W];
  assign overflow  = is_arith(sel)
                   & (op_x[OPERAND_W-1] == op_y[OPERAND_W-1])
                   & (sum[OPERAND_W-1] != op_x[OPERAND_W-1]);

endmodule

// File: rtl/alu_74382_wide_seq.sv
// Runs a wide operation through one alu_74382 slice, one chunk per cycle, LSB
// chunk first, with carry registered between chunks; result returned on a handshake.
module alu_74382_wide_seq
  import alu_74382_pkg::*;
#(
  parameter int OPERAND_W = 4,
  parameter int SLICES    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_sel,
  input  logic                          in_carry,
  input  logic [OPERAND_W*SLICES-1:0]   in_a,
  input  logic [OPERAND_W*SLICES-1:0]   in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OPERAND_W*SLICES-1:0]   out_result,
  output logic                          out_carry,
  output logic                          out_overflow
);

  localparam int W     = OPERAND_W * SLICES;
  localparam int CNT_W = $clog2(SLICES);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);

  state_e           state_q;
  logic [2:0]       sel_q;
  logic             carry_q;
  logic             ovf_q;
  logic [W-1:0]     a_sh_q;
  logic [W-1:0]     b_sh_q;
  logic [W-1:0]     res_sh_q;
  logic [CNT_W-1:0] slice_cnt_q;

  logic [W-1:0]     a_sh_d;
  logic [W-1:0]     b_sh_d;
  logic [W-1:0]     res_sh_d;
  logic [CNT_W-1:0] slice_cnt_d;

  logic [OPERAND_W-1:0] slice_result;
  logic                 slice_carry;
  logic                 slice_ovf;

  alu_74382 #(
    .OPERAND_W (OPERAND_W),
    .RESULT_W  (OPERAND_W)
  ) u_slice (
    .sel       (sel_q),
    .carry_in  (carry_q),
    .port_a    (a_sh_q[OPERAND_W-1:0]),
    .port_b    (b_sh_q[OPERAND_W-1:0]),
    .result    (slice_result),
    .carry_out (slice_carry),
    .overflow  (slice_ovf)
  );

  // After SLICES shifts the first (LSB) chunk has walked down to the bottom of res_sh.
  always_comb begin
    a_sh_d      = a_sh_q >> OPERAND_W;
    b_sh_d      = b_sh_q >> OPERAND_W;
    res_sh_d    = {slice_result, res_sh_q[W-1:OPERAND_W]};
    slice_cnt_d = slice_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      slice_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sel_q       <= in_sel;
            carry_q     <= in_carry;
            ovf_q       <= 1'b0;
            a_sh_q      <= in_a;
            b_sh_q      <= in_b;
            res_sh_q    <= '0;
            slice_cnt_q <= '0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          a_sh_q      <= a_sh_d;
          b_sh_q      <= b_sh_d;
          res_sh_q    <= res_sh_d;
          carry_q     <= slice_carry;
          ovf_q       <= slice_ovf;
          slice_cnt_q <= slice_cnt_d;
          if (slice_cnt_q == LAST_SLICE) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are gated by state so a partially assembled result is never visible.
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_result   = out_valid ? res_sh_q : '0;
  assign out_carry    = out_valid & is_arith(sel_q) & carry_q;
  assign out_overflow = out_valid & is_arith(sel_q) & ovf_q;

endmodule

// File: tb/tb_alu_74382_wide_seq.sv
// Directed bench for alu_74382_wide_seq (OPERAND_W=4, SLICES=4): vector table plus
// hand-written backpressure and mid-RUN reset sequences.
module tb_alu_74382_wide_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic        in_carry;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_carry;
  logic        out_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_74382_wide_seq #(
    .OPERAND_W (4),
    .SLICES    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sel       (in_sel),
    .in_carry     (in_carry),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow)
  );

  typedef struct {
    logic [2:0]  sel;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        carry;
    logic        ovf;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Issues one request, waits (bounded) for out_valid, captures outputs, then takes them.
  task automatic do_op(input logic [2:0] sel, input logic cin, input logic [15:0] a,
                       input logic [15:0] b, output logic [15:0] res, output logic c,
                       output logic o, output int lat);
    @(negedge clk);
    check("in_ready before issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_sel   = sel;
    in_carry = cin;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    c   = out_carry;
    o   = out_overflow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    logic        c;
    logic        o;
    int          lat;

    vecs[0]  = '{3'b011, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{3'b011, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[2]  = '{3'b011, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{3'b010, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    vecs[4]  = '{3'b001, 1'b1, 16'h0003, 16'h0010, 16'h000D, 1'b1, 1'b0};
    vecs[5]  = '{3'b110, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 1'b0, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b0};
    vecs[7]  = '{3'b101, 1'b1, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0};
    vecs[8]  = '{3'b000, 1'b1, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{3'b111, 1'b0, 16'hF0F0, 16'h3C3C, 16'hFFFF, 1'b0, 1'b0};
    vecs[10] = '{3'b011, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{3'b011, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 3'b000;
    in_carry  = 1'b0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_result", {16'd0, out_result}, 32'd0);
    check("reset out_carry", {31'd0, out_carry}, 32'd0);
    check("reset out_overflow", {31'd0, out_overflow}, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].sel, vecs[i].cin, vecs[i].a, vecs[i].b, r, c, o, lat);
      $display("vec %0d sel=%b cin=%b a=%h b=%h -> res=%h carry=%b ovf=%b latency=%0d",
               i, vecs[i].sel, vecs[i].cin, vecs[i].a, vecs[i].b, r, c, o, lat);
      check($sformatf("vec%0d latency", i), lat, 5);
      check($sformatf("vec%0d result", i), {16'd0, r}, {16'd0, vecs[i].res});
      check($sformatf("vec%0d carry", i), {31'd0, c}, {31'd0, vecs[i].carry});
      check($sformatf("vec%0d overflow", i), {31'd0, o}, {31'd0, vecs[i].ovf});
    end

    // Backpressure: AND request, then a second request held on in_valid throughout.
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = 3'b110;
    in_carry = 1'b0;
    in_a     = 16'hF0F0;
    in_b     = 16'h3C3C;
    @(negedge clk);
    in_sel   = 3'b011;
    in_a     = 16'h0001;
    in_b     = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp run%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp run%0d out_valid", k), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp stall%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp stall%0d result", k), {16'd0, out_result}, 32'h3030);
      check($sformatf("bp stall%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    check("bp take result", {16'd0, out_result}, 32'h3030);
    check("bp take in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp idle in_ready", {31'd0, in_ready}, 32'd1);
    check("bp idle out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp second accepted", {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    $display("backpressure second op res=%h latency=%0d", out_result, lat);
    check("bp second latency", lat, 5);
    check("bp second result", {16'd0, out_result}, 32'h0003);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the second RUN cycle.
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = 3'b111;
    in_carry = 1'b1;
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst out_result", {16'd0, out_result}, 32'd0);
    check("midrst out_carry", {31'd0, out_carry}, 32'd0);
    check("midrst out_overflow", {31'd0, out_overflow}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("midrst quiet%0d out_valid", k), {31'd0, out_valid}, 32'd0);
    end
    do_op(3'b011, 1'b0, 16'h1234, 16'h1111, r, c, o, lat);
    $display("post-reset op a=1234 b=1111 -> res=%h carry=%b ovf=%b latency=%0d", r, c, o, lat);
    check("post-reset latency", lat, 5);
    check("post-reset result", {16'd0, r}, 32'h2345);
    check("post-reset carry", {31'd0, c}, 32'd0);
    check("post-reset overflow", {31'd0, o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
